// File: rtl/kalman_ab_track.sv
// Fixed-gain alpha-beta tracker, one position/velocity filter per channel.
// Sequenced predict -> innovation -> update -> emit over four cycles per request.
module kalman_ab_track #(
  parameter int DISP_WIDTH = 11,
  parameter int NUM_CH     = 2,
  parameter int FRAC_W     = 8,
  parameter int ALPHA_SH   = 1,
  parameter int BETA_SH    = 2,
  parameter int MAX_COAST  = 15
) (
  input  logic                           clk,
  input  logic                           aresetn,
  input  logic [NUM_CH*DISP_WIDTH-1:0]   z_in,
  input  logic                           z_valid,
  input  logic                           coast,
  output logic                           z_ready,
  output logic [NUM_CH*DISP_WIDTH-1:0]   z_out,
  output logic                           out_valid,
  output logic                           locked
);

  localparam int STATE_W = DISP_WIDTH + FRAC_W + 2;
  localparam int CNT_W   = $clog2(MAX_COAST + 2);

  localparam logic signed [STATE_W-1:0] S_MAX = {1'b0, {(STATE_W-1){1'b1}}};
  localparam logic signed [STATE_W-1:0] S_MIN = {1'b1, {(STATE_W-1){1'b0}}};
  localparam logic signed [STATE_W:0]   HALF  =
    {{(STATE_W+1-FRAC_W){1'b0}}, 1'b1, {(FRAC_W-1){1'b0}}};
  localparam logic signed [STATE_W:0]   PIX_MAX =
    {{(STATE_W+1-DISP_WIDTH){1'b0}}, {DISP_WIDTH{1'b1}}};
  localparam logic [CNT_W-1:0] COAST_LIMIT = CNT_W'(MAX_COAST);

  typedef enum logic [2:0] {IDLE, PREDICT, INNOV, UPDATE, EMIT} state_t;

  state_t                          state_reg;
  logic                            is_meas_reg;
  logic [NUM_CH*DISP_WIDTH-1:0]    z_cap_reg;
  logic [CNT_W-1:0]                coast_cnt_reg;
  logic                            locked_reg;
  logic                            out_valid_reg;
  logic                            clear_track;

  function automatic logic signed [STATE_W-1:0] sat_add(
    input logic signed [STATE_W-1:0] a,
    input logic signed [STATE_W-1:0] b
  );
    logic signed [STATE_W:0] s;
    s = {a[STATE_W-1], a} + {b[STATE_W-1], b};
    if (s[STATE_W] != s[STATE_W-1]) return s[STATE_W] ? S_MIN : S_MAX;
    return s[STATE_W-1:0];
  endfunction

  function automatic logic signed [STATE_W-1:0] sat_sub(
    input logic signed [STATE_W-1:0] a,
    input logic signed [STATE_W-1:0] b
  );
    logic signed [STATE_W:0] s;
    s = {a[STATE_W-1], a} - {b[STATE_W-1], b};
    if (s[STATE_W] != s[STATE_W-1]) return s[STATE_W] ? S_MIN : S_MAX;
    return s[STATE_W-1:0];
  endfunction

  // Round half up to whole pixels, then clamp into the displayable range.
  function automatic logic [DISP_WIDTH-1:0] to_pixel(input logic signed [STATE_W-1:0] p);
    logic signed [STATE_W:0] ext;
    logic signed [STATE_W:0] q;
    ext = {p[STATE_W-1], p};
    ext = ext + HALF;
    q   = ext >>> FRAC_W;
    if (q < 0) return '0;
    if (q > PIX_MAX) return {DISP_WIDTH{1'b1}};
    return q[DISP_WIDTH-1:0];
  endfunction

  assign z_ready     = aresetn && (state_reg == IDLE);
  assign out_valid   = out_valid_reg;
  assign locked      = locked_reg;
  assign clear_track = (state_reg == EMIT) && !is_meas_reg && (coast_cnt_reg == COAST_LIMIT);

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      state_reg     <= IDLE;
      is_meas_reg   <= 1'b0;
      z_cap_reg     <= '0;
      coast_cnt_reg <= '0;
      locked_reg    <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      out_valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          // A measurement always wins over a simultaneous coast request.
          if (z_valid) begin
            z_cap_reg   <= z_in;
            is_meas_reg <= 1'b1;
            state_reg   <= PREDICT;
          end else if (coast && locked_reg) begin
            is_meas_reg <= 1'b0;
            state_reg   <= PREDICT;
          end
        end
        PREDICT: state_reg <= INNOV;
        INNOV:   state_reg <= UPDATE;
        UPDATE: begin
          state_reg     <= EMIT;
          out_valid_reg <= 1'b1;
          if (is_meas_reg) coast_cnt_reg <= '0;
          else             coast_cnt_reg <= coast_cnt_reg + 1'b1;
        end
        EMIT: begin
          state_reg <= IDLE;
          if (is_meas_reg) begin
            locked_reg <= 1'b1;
          end else if (clear_track) begin
            locked_reg    <= 1'b0;
            coast_cnt_reg <= '0;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic signed [STATE_W-1:0] p_reg, v_reg, pp_reg, r_reg;
      logic signed [STATE_W-1:0] p_next, v_next;
      logic signed [STATE_W-1:0] z_fix;
      logic [DISP_WIDTH-1:0]     z_out_reg;

      assign z_fix = {2'b00, z_cap_reg[gi*DISP_WIDTH +: DISP_WIDTH], {FRAC_W{1'b0}}};
      assign z_out[gi*DISP_WIDTH +: DISP_WIDTH] = z_out_reg;

      always_comb begin
        p_next = pp_reg;
        v_next = v_reg;
        if (is_meas_reg && locked_reg) begin
          p_next = sat_add(pp_reg, r_reg >>> ALPHA_SH);
          v_next = sat_add(v_reg,  r_reg >>> BETA_SH);
        end else if (is_meas_reg) begin
          p_next = z_fix;
          v_next = '0;
        end
      end

      // The pixel output is taken from the freshly updated position so it
      // becomes visible in the same cycle as the out_valid pulse.
      always_ff @(posedge clk) begin
        if (!aresetn) begin
          p_reg     <= '0;
          v_reg     <= '0;
          pp_reg    <= '0;
          r_reg     <= '0;
          z_out_reg <= '0;
        end else begin
          case (state_reg)
            PREDICT: pp_reg <= sat_add(p_reg, v_reg);
            INNOV:   r_reg  <= sat_sub(z_fix, pp_reg);
            UPDATE: begin
              p_reg     <= p_next;
              v_reg     <= v_next;
              z_out_reg <= to_pixel(p_next);
            end
            EMIT: begin
              if (clear_track) begin
                p_reg <= '0;
                v_reg <= '0;
              end
            end
            default: ;
          endcase
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_kalman_ab_track.sv
// Directed bench: default tracker plus a MAX_COAST=3 copy sharing clock, reset and z_in.
module tb_kalman_ab_track;
  localparam int DW = 11;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          aresetn;
  logic [2*DW-1:0] z_in;
  logic          zv0, cs0, zv1, cs1;
  logic          rdy0, ov0, lk0, rdy1, ov1, lk1;
  logic [2*DW-1:0] zo0, zo1;

  kalman_ab_track dut (
    .clk(clk), .aresetn(aresetn), .z_in(z_in), .z_valid(zv0), .coast(cs0),
    .z_ready(rdy0), .z_out(zo0), .out_valid(ov0), .locked(lk0)
  );

  kalman_ab_track #(.MAX_COAST(3)) dut_mc (
    .clk(clk), .aresetn(aresetn), .z_in(z_in), .z_valid(zv1), .coast(cs1),
    .z_ready(rdy1), .z_out(zo1), .out_valid(ov1), .locked(lk1)
  );

  int checks = 0;
  int errors = 0;
  int npulse, pcyc, ox, oy, lkd, busy_rdy, rdy_before, rdy_after;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // One request to the selected instance, then watch six cycles for its pulse.
  task automatic req(input int sel, input bit m, input bit c, input int zx, input int zy,
                     input string tag);
    @(negedge clk);
    z_in = {zy[DW-1:0], zx[DW-1:0]};
    rdy_before = (sel == 1) ? int'(rdy1) : int'(rdy0);
    if (sel == 1) begin zv1 = m; cs1 = c; end
    else          begin zv0 = m; cs0 = c; end
    npulse = 0;
    pcyc   = 0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) begin
        zv0 = 1'b0; cs0 = 1'b0; zv1 = 1'b0; cs1 = 1'b0;
        busy_rdy = (sel == 1) ? int'(rdy1) : int'(rdy0);
      end
      if (((sel == 1) ? ov1 : ov0) === 1'b1) begin
        npulse++;
        pcyc = k;
      end
    end
    ox        = (sel == 1) ? int'(zo1[DW-1:0])  : int'(zo0[DW-1:0]);
    oy        = (sel == 1) ? int'(zo1[2*DW-1:DW]) : int'(zo0[2*DW-1:DW]);
    lkd       = (sel == 1) ? int'(lk1) : int'(lk0);
    rdy_after = (sel == 1) ? int'(rdy1) : int'(rdy0);
    $display("txn %s: meas=%0b coast=%0b z=(%0d,%0d) pulses=%0d at c+%0d z_out=(%0d,%0d) locked=%0d",
             tag, m, c, zx, zy, npulse, pcyc, ox, oy, lkd);
  endtask

  task automatic expect_txn(input string tag, input int ex, input int ey, input int el);
    chk({tag, ".pulses"}, npulse, 1);
    chk({tag, ".latency"}, pcyc, 4);
    chk({tag, ".x"}, ox, ex);
    chk({tag, ".y"}, oy, ey);
    chk({tag, ".locked"}, lkd, el);
  endtask

  task automatic do_reset();
    @(negedge clk);
    aresetn = 1'b0;
    repeat (2) @(negedge clk);
    aresetn = 1'b1;
  endtask

  int xs_p[5] = '{2000, 2032, 2024, 2032, 2040};
  int ex_p[5] = '{2000, 2016, 2024, 2032, 2040};
  int xs_n[5] = '{47, 15, 23, 15, 7};
  int ex_n[5] = '{47, 31, 23, 15, 7};

  initial begin
    aresetn = 1'b0;
    z_in = '0;
    zv0 = 1'b0; cs0 = 1'b0; zv1 = 1'b0; cs1 = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst.z_ready", int'(rdy0), 0);
    chk("rst.out_valid", int'(ov0), 0);
    chk("rst.locked", int'(lk0), 0);
    chk("rst.z_out", int'(zo0), 0);
    aresetn = 1'b1;
    @(negedge clk);
    chk("rst.z_ready_after", int'(rdy0), 1);

    // First lock, then a locked measurement and a coast
    req(0, 1'b1, 1'b0, 100, 200, "acq");
    expect_txn("acq", 100, 200, 1);
    chk("acq.busy_ready", busy_rdy, 0);
    req(0, 1'b1, 1'b0, 110, 200, "meas2");
    expect_txn("meas2", 105, 200, 1);
    req(0, 1'b0, 1'b1, 0, 0, "coast1");
    expect_txn("coast1", 108, 200, 1);

    // Upper clamp: build +8 px/frame at the right edge, then coast past it
    do_reset();
    for (int i = 0; i < 5; i++) begin
      req(0, 1'b1, 1'b0, xs_p[i], 500, "hi_meas");
      chk("hi_meas.x", ox, ex_p[i]);
    end
    req(0, 1'b0, 1'b1, 0, 0, "hi_coast1");
    expect_txn("hi_coast1", 2047, 500, 1);
    req(0, 1'b0, 1'b1, 0, 0, "hi_coast2");
    expect_txn("hi_coast2", 2047, 500, 1);

    // Lower clamp: mirrored track heading below zero
    do_reset();
    for (int i = 0; i < 5; i++) begin
      req(0, 1'b1, 1'b0, xs_n[i], 500, "lo_meas");
      chk("lo_meas.x", ox, ex_n[i]);
    end
    req(0, 1'b0, 1'b1, 0, 0, "lo_coast1");
    expect_txn("lo_coast1", 0, 500, 1);
    req(0, 1'b0, 1'b1, 0, 0, "lo_coast2");
    expect_txn("lo_coast2", 0, 500, 1);

    // Loss of lock after MAX_COAST=3 coasts; the next coast is dropped
    do_reset();
    req(1, 1'b1, 1'b0, 100, 200, "mc_acq");
    expect_txn("mc_acq", 100, 200, 1);
    req(1, 1'b0, 1'b1, 0, 0, "mc_c1");
    expect_txn("mc_c1", 100, 200, 1);
    req(1, 1'b0, 1'b1, 0, 0, "mc_c2");
    expect_txn("mc_c2", 100, 200, 1);
    req(1, 1'b0, 1'b1, 0, 0, "mc_c3");
    expect_txn("mc_c3", 100, 200, 0);
    req(1, 1'b0, 1'b1, 0, 0, "mc_c4");
    chk("mc_c4.ready_before", rdy_before, 1);
    chk("mc_c4.pulses", npulse, 0);
    chk("mc_c4.ready_after", rdy_after, 1);
    chk("mc_c4.busy_ready", busy_rdy, 1);
    chk("mc_c4.x_hold", ox, 100);

    // Both requests together act as a measurement and clear the coast count
    req(1, 1'b1, 1'b0, 100, 200, "both_acq");
    expect_txn("both_acq", 100, 200, 1);
    req(1, 1'b0, 1'b1, 0, 0, "both_c1");
    expect_txn("both_c1", 100, 200, 1);
    req(1, 1'b0, 1'b1, 0, 0, "both_c2");
    expect_txn("both_c2", 100, 200, 1);
    req(1, 1'b1, 1'b1, 104, 200, "both_req");
    expect_txn("both_req", 102, 200, 1);
    req(1, 1'b0, 1'b1, 0, 0, "both_c3");
    expect_txn("both_c3", 103, 200, 1);
    req(1, 1'b0, 1'b1, 0, 0, "both_c4");
    expect_txn("both_c4", 104, 200, 1);
    req(1, 1'b0, 1'b1, 0, 0, "both_c5");
    expect_txn("both_c5", 105, 200, 0);

    // Reset pulse while the frame is in INNOV abandons it
    req(0, 1'b1, 1'b0, 300, 400, "pre_abort");
    expect_txn("pre_abort", 300, 400, 1);
    @(negedge clk);
    z_in = {11'd401, 11'd301};
    zv0 = 1'b1;
    @(negedge clk);
    zv0 = 1'b0;
    @(negedge clk);
    aresetn = 1'b0;
    #1;
    chk("abort.ready_in_reset", int'(rdy0), 0);
    @(negedge clk);
    chk("abort.locked", int'(lk0), 0);
    chk("abort.z_out", int'(zo0), 0);
    chk("abort.out_valid", int'(ov0), 0);
    aresetn = 1'b1;
    #1;
    chk("abort.idle_ready", int'(rdy0), 1);
    npulse = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (ov0 === 1'b1) npulse++;
    end
    chk("abort.pulses", npulse, 0);
    $display("txn abort: pulses=%0d locked=%0d z_out=%0d", npulse, lk0, zo0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/kalman_ab_track.md
KALMAN_AB_TRACK -- requirements
Module: kalman_ab_track

Interface
REQ-001 Parameter DISP_WIDTH, default 11: unsigned coordinate width per channel.
REQ-002 Parameter NUM_CH, default 2: independent channels (x, y, ...), all processed in parallel.
REQ-003 Parameter FRAC_W, default 8: fractional bits of internal state.
REQ-004 Parameter ALPHA_SH, default 1: position gain = 2^-ALPHA_SH.
REQ-005 Parameter BETA_SH, default 2: velocity gain = 2^-BETA_SH.
REQ-006 Parameter MAX_COAST, default 15: consecutive coasts tolerated before loss of lock.
REQ-007 clk  in  1  sole clock; all logic on posedge.
REQ-008 aresetn  in  1  synchronous, active-low reset.
REQ-009 z_in  in  NUM_CH*DISP_WIDTH  measurements; channel k at bits [k*DISP_WIDTH +: DISP_WIDTH].
REQ-010 z_valid  in  1  measurement request.
REQ-011 coast  in  1  predict-only request (no measurement this frame).
REQ-012 z_ready  out  1  high when a request can be accepted.
REQ-013 z_out  out  NUM_CH*DISP_WIDTH  filtered positions, same packing as z_in.
REQ-014 out_valid  out  1  single-cycle pulse: z_out updated.
REQ-015 locked  out  1  filter holds a valid track.

Function
REQ-016 State per channel: position p, velocity v, signed, STATE_W = DISP_WIDTH+FRAC_W+2 bits, FRAC_W fractional.
REQ-017 FSM states IDLE -> PREDICT -> INNOV -> UPDATE -> EMIT -> IDLE; one cycle each except IDLE.
REQ-018 z_ready = 1 only in IDLE and when aresetn high; z_in captured into a register on acceptance.
REQ-019 Acceptance in IDLE: z_valid=1 accepts a measurement; else coast=1 with locked=1 accepts a coast; coast with locked=0 is dropped (stay IDLE, no output).
REQ-020 z_valid and coast both high: measurement wins, coast ignored.
REQ-021 Latency: acceptance in cycle c -> out_valid high in cycle c+4 only; next acceptance earliest in c+5.
REQ-022 PREDICT: pp = p + v, saturated to STATE_W signed range.
REQ-023 INNOV: r = (z << FRAC_W) - pp, computed in STATE_W+1 bits, saturated to STATE_W.
REQ-024 UPDATE (measurement, locked=1): p <= sat(pp + (r >>> ALPHA_SH)); v <= sat(v + (r >>> BETA_SH)); arithmetic shift.
REQ-025 UPDATE (measurement, locked=0): p <= z << FRAC_W; v <= 0; locked set at EMIT.
REQ-026 UPDATE (coast): p <= pp; v unchanged.
REQ-027 EMIT: z_out per channel = round-half-up(p >> FRAC_W), clamped to [0, 2^DISP_WIDTH-1]; out_valid=1.
REQ-028 Coast counter: cleared by every measurement; +1 per coast; when it reaches MAX_COAST at EMIT, locked clears, p/v/counter zeroed (that output still emitted).
REQ-029 z_out holds its last value between out_valid pulses.
REQ-030 Requests arriving outside IDLE are ignored (not queued).

Reset
REQ-031 aresetn low at a posedge: FSM IDLE, p, v, counter, z_out = 0, out_valid = 0, locked = 0, z_ready = 0 while aresetn low.
REQ-032 Reset mid-operation abandons the frame: no out_valid pulse afterwards for it.

Verification (defaults except noted)
REQ-033 Reset, then z_valid with (100,200) -> out_valid in c+4, z_out=(100,200), locked=1, exactly one pulse.
REQ-034 Then measurement (110,200) -> z_out=(105,200); then coast -> z_out=(108,200) (107.5 rounded up).
REQ-035 MAX_COAST=3: lock, then 3 coasts -> 3 pulses, locked=0 after third; fourth coast dropped, z_ready stays 1, no pulse.
REQ-036 Track at 2040 with velocity +8 px/frame, coast x2 -> z_out x=2047 (clamped); mirrored negative case -> 0.
REQ-037 z_valid and coast high together in IDLE -> treated as measurement; coast counter 0.
REQ-038 aresetn low for one cycle during INNOV -> no out_valid pulse, locked=0, z_out=0, IDLE next cycle.
